// File: rtl/rs_encode_wrapper.sv
// Byte-serial systematic RS(15,11) encoder over GF(2^8) (poly 0x11D).
// Latches an 11-byte message, runs it through a 4-stage parity LFSR, then emits message + parity.
module rs_encode_wrapper #(
  parameter int K = 11,
  parameter int N = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clrn,
  input  logic           encode_en,
  input  logic [K*8-1:0] message,
  output logic [N*8-1:0] encoded_data,
  output logic           output_valid,
  output logic           ready,
  output logic           encode_complete
);

  typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, COMPLETE = 2'd2} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [K*8-1:0] msg_q, msg_d;
  logic [7:0]     p3_q, p2_q, p1_q, p0_q;
  logic [7:0]     p3_d, p2_d, p1_d, p0_d;
  logic [N*8-1:0] enc_q, enc_d;
  logic           vld_q, vld_d, rdy_q, rdy_d, done_q, done_d;
  logic [7:0]     fb;

  // msg_q rotates one byte per FEED cycle; after K rotations it is back in place for COMPLETE.
  assign fb = msg_q[7:0] ^ p3_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    p3_d    = p3_q;
    p2_d    = p2_q;
    p1_d    = p1_q;
    p0_d    = p0_q;
    enc_d   = enc_q;
    vld_d   = vld_q;
    rdy_d   = rdy_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (encode_en) begin
          msg_d   = message;
          p3_d    = 8'h00;
          p2_d    = 8'h00;
          p1_d    = 8'h00;
          p0_d    = 8'h00;
          cnt_d   = 4'd0;
          rdy_d   = 1'b0;
          vld_d   = 1'b0;
          state_d = FEED;
        end
      end
      FEED: begin
        p3_d  = p2_q ^ gf_mul(fb, 8'h0F);
        p2_d  = p1_q ^ gf_mul(fb, 8'h36);
        p1_d  = p0_q ^ gf_mul(fb, 8'h78);
        p0_d  = gf_mul(fb, 8'h40);
        msg_d = {msg_q[7:0], msg_q[K*8-1:8]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(K - 1)) state_d = COMPLETE;
      end
      COMPLETE: begin
        enc_d   = {p0_q, p1_q, p2_q, p3_q, msg_q};
        vld_d   = 1'b1;
        done_d  = 1'b1;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      msg_q   <= '0;
      p3_q    <= '0;
      p2_q    <= '0;
      p1_q    <= '0;
      p0_q    <= '0;
      enc_q   <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
    end else if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      msg_q   <= '0;
      p3_q    <= '0;
      p2_q    <= '0;
      p1_q    <= '0;
      p0_q    <= '0;
      enc_q   <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      msg_q   <= msg_d;
      p3_q    <= p3_d;
      p2_q    <= p2_d;
      p1_q    <= p1_d;
      p0_q    <= p0_d;
      enc_q   <= enc_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

  assign encoded_data    = enc_q;
  assign output_valid    = vld_q;
  assign ready           = rdy_q;
  assign encode_complete = done_q;

endmodule

// File: doc/rs_encode_wrapper.md
# rs_encode_wrapper

Byte-serial systematic Reed-Solomon encoder front end, the transmit-side counterpart of the RS decode wrapper. It latches an 11-byte message and clocks it through an internal GF(2^8) parity LFSR one byte per cycle. It emits a 15-byte codeword: 11 message bytes plus 4 parity bytes. The codeword byte layout is exactly what `rs_decode_wrapper` consumes on `encoded_data`, so an unmodified codeword decodes with `with_error = 0`.

## Interface
- `K`, 11: message bytes per codeword.
- `N`, 15: codeword bytes. Fixed by the decoder; `N - K = 4` parity bytes.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset. All state returns to reset values immediately.
- `clrn`  in  1  synchronous clear, active-low. Same effect as `rst`, applied at the clock edge.
- `encode_en`  in  1  start request. Accepted only while `ready = 1`, i.e. in state IDLE.
- `message`  in  K*8  message. Byte i is `message[i*8 +: 8]`; byte 0 is sent first and is the highest-degree symbol.
- `encoded_data`  out  N*8  codeword. Bytes 0..10 equal the message; bytes 11..14 are parity p3, p2, p1, p0.
- `output_valid`  out  1  `encoded_data` holds the result of the most recent encode.
- `ready`  out  1  block is idle and will accept `encode_en`.
- `encode_complete`  out  1  one-cycle pulse when an encode finishes.

## Operation
- Field: GF(2^8), primitive polynomial 0x11D.
- Generator polynomial: g(x) = x^4 + 0x0F·x^3 + 0x36·x^2 + 0x78·x + 0x40, with roots alpha^0..alpha^3.
- Codeword: c(x) = m(x)·x^4 + (m(x)·x^4 mod g(x)), where m(x) = sum of byte_i·x^(10-i).
- Parity LFSR registers p3..p0 are 8 bits each. Per absorbed byte b:
  - f = b ^ p3
  - p3 <= p2 ^ f·0x0F
  - p2 <= p1 ^ f·0x36
  - p1 <= p0 ^ f·0x78
  - p0 <= f·0x40
- GF multiplies are constant multipliers, purely combinational. Additions are XOR. No carries; all values stay 8 bits wide.
- State machine with 4-bit byte counter `cnt`:
  - IDLE: `encode_complete <= 0`. If `encode_en`: latch `message` into `msg_q`, clear p3..p0, `cnt <= 0`, `ready <= 0`, `output_valid <= 0`, go to FEED.
  - FEED: absorb `msg_q` byte `cnt` and increment `cnt`. When `cnt == K-1`, that byte is the last one; go to COMPLETE.
  - COMPLETE: load `encoded_data` with {p0, p1, p2, p3, msg_q}, with p3 at byte 11. Set `output_valid <= 1`, `encode_complete <= 1`, `ready <= 1`; go to IDLE.
  - Undefined state encodings go to IDLE.
- `message` is sampled only on the accepting edge. Later changes to it do not affect the encode in progress.
- `encode_en` outside IDLE is ignored. There is no queuing.
- `encoded_data` holds its value until the next COMPLETE. It is zeroed only by `rst` or `clrn`.

## Timing
- Reset values (`rst` or `!clrn`): state IDLE, `ready = 1`, `output_valid = 0`, `encode_complete = 0`, `encoded_data = 0`, `cnt = 0`, p3..p0 = 0, `msg_q = 0`.
- Edge E0 accepts `encode_en`. From E0 through E12, `ready = 0`.
  - Edges E1..E11 absorb bytes 0..10.
  - Edge E12 executes COMPLETE.
  - After E12: `output_valid = 1`, `encode_complete = 1`, `ready = 1`, codeword stable.
- Latency is 12 cycles from acceptance to valid output.
- `encode_complete` is high for exactly one cycle and clears at E13.
- Back-to-back: `encode_en` held high is accepted again at E13. `output_valid` falls after E13. Maximum throughput is one codeword per 13 cycles.
- Reset mid-operation: `rst` or `!clrn` during FEED or COMPLETE aborts the encode.
  - No `encode_complete` pulse is produced.
  - Outputs take their reset values.
- `rst` overrides `clrn`. `clrn` overrides `encode_en` on the same edge.

## Test plan
- Reset, then all-zero message with `encode_en` held for 1 cycle -> after 12 cycles `encoded_data == 0`, `output_valid = 1`, a single-cycle `encode_complete`, `ready` low for exactly 12 cycles.
- Message with byte 10 = 0x01, all other bytes 0 -> codeword bytes 11..14 = 0x0F, 0x36, 0x78, 0x40; bytes 0..10 equal the message.
- Linearity: encode random A, B, and A^B -> cw(A^B) == cw(A)^cw(B) over 200 random pairs. Every codeword, fed into `rs_decode_wrapper`, gives `with_error = 0`. The same codewords with one byte flipped give `with_error = 1`.
- Toggle `message` and pulse `encode_en` during FEED -> the result matches the originally latched message, and exactly one `encode_complete` pulse occurs.
- `encode_en` held high continuously for 3 encodes -> acceptances 13 cycles apart, 3 pulses, each codeword correct.
- Assert `rst` at cycle 6 of FEED, and separately drive `clrn = 0` at cycle 6 of FEED -> outputs immediately (`rst`) or at the next edge (`clrn`) take their reset values, with no `encode_complete`. A subsequent encode is correct.
